// File: rtl/network_sequencer.sv
// On-chip sequencer for the LSTM + perceptron network: feeds input vectors, waits
// for the step/perceptron completion edges, returns results and resets per sequence.
`timescale 1ns/1ps
module network_sequencer #(
    parameter int INPUT_SZ   = 2,
    parameter int QN         = 6,
    parameter int QM         = 11,
    parameter int SEQ_LEN    = 8,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [(QN+QM+1)*INPUT_SZ-1:0]   s_data,
    output logic [(QN+QM+1)*INPUT_SZ-1:0]   net_input,
    output logic                            net_newSample,
    output logic                            net_reset,
    input  logic                            net_dataReady,
    output logic                            net_enPerceptron,
    input  logic                            net_dataReadyP,
    input  logic [QN+QM:0]                  net_output,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [QN+QM:0]                  m_data,
    output logic                            m_last,
    output logic                            error
);
    localparam int BITWIDTH = QN + QM + 1;
    localparam int VEC_W    = BITWIDTH * INPUT_SZ;
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam int STEP_W   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SEQ_LEN - 1);
    localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        NET_RST,
        IDLE,
        ISSUE,
        WAIT_L,
        GAP,
        PERC,
        OUT
    } state_t;

    state_t              r_state;
    logic [STEP_W-1:0]   r_step;
    logic [RC_W-1:0]     r_rst_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_dr_q;
    logic                r_drp_q;
    logic [VEC_W-1:0]    r_net_input;
    logic                r_new_sample;
    logic                r_net_reset;
    logic                r_en_perc;
    logic                r_s_ready;
    logic                r_m_valid;
    logic [BITWIDTH-1:0] r_m_data;
    logic                r_m_last;
    logic                r_error;

    // Completions are rising edges only; a level held over from the previous step is ignored.
    logic w_dr_rise;
    logic w_drp_rise;
    logic w_timeout;
    assign w_dr_rise  = net_dataReady  & ~r_dr_q;
    assign w_drp_rise = net_dataReadyP & ~r_drp_q;
    assign w_timeout  = (r_to_cnt == TO_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= NET_RST;
            r_step       <= '0;
            r_rst_cnt    <= '0;
            r_to_cnt     <= '0;
            r_dr_q       <= 1'b0;
            r_drp_q      <= 1'b0;
            r_net_input  <= '0;
            r_new_sample <= 1'b0;
            r_net_reset  <= 1'b1;
            r_en_perc    <= 1'b0;
            r_s_ready    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_last     <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_dr_q  <= net_dataReady;
            r_drp_q <= net_dataReadyP;
            case (r_state)
                NET_RST: begin
                    r_step <= '0;
                    if (r_rst_cnt == RC_LAST) begin
                        r_net_reset <= 1'b0;
                        r_s_ready   <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RC_W'(1);
                    end
                end
                IDLE: begin
                    if (s_valid && r_s_ready) begin
                        r_net_input  <= s_data;
                        r_s_ready    <= 1'b0;
                        r_new_sample <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_new_sample <= 1'b0;
                    r_to_cnt     <= '0;
                    r_state      <= WAIT_L;
                end
                WAIT_L: begin
                    if (w_dr_rise) begin
                        r_state <= GAP;
                    end else if (w_timeout) begin
                        r_error     <= 1'b1;
                        r_net_reset <= 1'b1;
                        r_rst_cnt   <= '0;
                        r_state     <= NET_RST;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                GAP: begin
                    r_en_perc <= 1'b1;
                    r_to_cnt  <= '0;
                    r_state   <= PERC;
                end
                PERC: begin
                    if (w_drp_rise) begin
                        r_m_data  <= net_output;
                        r_m_last  <= (r_step == LAST_STEP);
                        r_m_valid <= 1'b1;
                        r_en_perc <= 1'b0;
                        r_state   <= OUT;
                    end else if (w_timeout) begin
                        r_en_perc   <= 1'b0;
                        r_error     <= 1'b1;
                        r_net_reset <= 1'b1;
                        r_rst_cnt   <= '0;
                        r_state     <= NET_RST;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_m_last  <= 1'b0;
                        if (r_step == LAST_STEP) begin
                            r_step      <= '0;
                            r_net_reset <= 1'b1;
                            r_rst_cnt   <= '0;
                            r_state     <= NET_RST;
                        end else begin
                            r_step    <= r_step + STEP_W'(1);
                            r_s_ready <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: begin
                    r_net_reset <= 1'b1;
                    r_rst_cnt   <= '0;
                    r_state     <= NET_RST;
                end
            endcase
        end
    end

    assign s_ready          = r_s_ready;
    assign net_input        = r_net_input;
    assign net_newSample    = r_new_sample;
    assign net_reset        = r_net_reset;
    assign net_enPerceptron = r_en_perc;
    assign m_valid          = r_m_valid;
    assign m_data           = r_m_data;
    assign m_last           = r_m_last;
    assign error            = r_error;

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench for network_sequencer with a behavioural LSTM/perceptron network model.
`timescale 1ns/1ps
module tb_network_sequencer;
    localparam int BW         = 18;
    localparam int VW         = 36;
    localparam int SEQ_LEN    = 8;
    localparam int RST_CYCLES = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [VW-1:0] s_data = '0;
    logic [VW-1:0] net_input;
    logic          net_newSample;
    logic          net_reset;
    logic          net_dataReady;
    logic          net_enPerceptron;
    logic          net_dataReadyP;
    logic [BW-1:0] net_output;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [BW-1:0] m_data;
    logic          m_last;
    logic          error;

    int checks = 0;
    int failures = 0;
    int step_tb = 0;

    logic [BW-1:0] exp_data_q[$];
    logic          exp_last_q[$];

    // Network model state
    int   lstm_delay = 20;
    int   perc_delay = 10;
    bit   manual_dr = 1'b0;
    logic man_dr = 1'b1;
    logic man_dr_q;
    logic mdl_dr, mdl_drp;
    int   lcnt, pcnt;
    bit   l_act, p_act;

    always #5 clock = ~clock;

    network_sequencer #(
        .INPUT_SZ(2), .QN(6), .QM(11), .SEQ_LEN(SEQ_LEN), .RST_CYCLES(RST_CYCLES), .TIMEOUT(1023)
    ) dut (
        .clock(clock), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .net_input(net_input), .net_newSample(net_newSample), .net_reset(net_reset),
        .net_dataReady(net_dataReady), .net_enPerceptron(net_enPerceptron),
        .net_dataReadyP(net_dataReadyP), .net_output(net_output),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .error(error)
    );

    // Network output: element0 halved (arithmetic) plus element1 minus 1.0 (Q6.11)
    function automatic logic [BW-1:0] mdl_out(input logic [VW-1:0] v);
        logic signed [BW-1:0] e0;
        logic [BW-1:0]        e1;
        e0 = v[BW-1:0];
        e1 = v[VW-1:BW];
        return BW'(e0 >>> 1) + e1 - 18'h00800;
    endfunction

    assign net_dataReady  = manual_dr ? man_dr_q : mdl_dr;
    assign net_dataReadyP = mdl_drp;
    assign net_output     = mdl_out(net_input);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mdl_dr <= 1'b0; mdl_drp <= 1'b0; man_dr_q <= 1'b0;
            l_act <= 1'b0; p_act <= 1'b0; lcnt <= 0; pcnt <= 0;
        end else begin
            man_dr_q <= man_dr;
            if (net_newSample) begin
                mdl_dr <= 1'b0; mdl_drp <= 1'b0; p_act <= 1'b0;
                l_act <= (lstm_delay > 0); lcnt <= lstm_delay;
            end else begin
                if (l_act) begin
                    if (lcnt <= 1) begin l_act <= 1'b0; mdl_dr <= 1'b1; end
                    else lcnt <= lcnt - 1;
                end
                if (net_enPerceptron && !p_act && !mdl_drp) begin
                    p_act <= 1'b1; pcnt <= perc_delay;
                end else if (p_act) begin
                    if (pcnt <= 1) begin p_act <= 1'b0; mdl_drp <= 1'b1; end
                    else pcnt <= pcnt - 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[VW-1:0];
    endfunction

    // Called on the first cycle net_reset is high; measures the pulse length.
    task automatic expect_reset_pulse(input string name);
        int n;
        bit bad;
        n = 0; bad = 1'b0;
        while (net_reset === 1'b1 && n < 50) begin
            if (net_newSample !== 1'b0 || net_enPerceptron !== 1'b0 || s_ready !== 1'b0) bad = 1'b1;
            n++;
            tick();
        end
        checks++;
        if (n != RST_CYCLES) begin
            failures++;
            $display("FAIL %s_len got=%0d exp=%0d", name, n, RST_CYCLES);
        end
        checks++;
        if (s_ready !== 1'b1 || bad) begin
            failures++;
            $display("FAIL %s_after got s_ready=%b glitch=%0b exp s_ready=1 glitch=0", name, s_ready, bad);
        end
    endtask

    task automatic run_sample(input logic [VW-1:0] d, input int hold, input bit hold_dr_mode);
        logic [BW-1:0] ed;
        logic          el;
        int n, dr_i, drp_i, en_i, mv_i, extra_ns;
        logic prev_dr, prev_drp;
        bit bad;
        exp_data_q.push_back(mdl_out(d));
        exp_last_q.push_back(step_tb == SEQ_LEN - 1);

        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL s_ready_wait got=%b exp=1", s_ready);
        end
        s_valid = 1'b1; s_data = d;
        tick();
        s_valid = 1'b0;
        checks++;
        if (net_newSample !== 1'b1) begin
            failures++;
            $display("FAIL newsample_pulse got=%b exp=1", net_newSample);
        end
        checks++;
        if (net_input !== d) begin
            failures++;
            $display("FAIL net_input got=%h exp=%h", net_input, d);
        end

        if (hold_dr_mode) begin
            bad = 1'b0;
            for (int i = 0; i < 15; i++) begin
                tick();
                if (net_enPerceptron !== 1'b0 || m_valid !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL hold_dr_skip got=advanced exp=waiting");
            end
            man_dr = 1'b0;
            tick(); tick();
        end
        prev_dr = net_dataReady; prev_drp = net_dataReadyP;
        if (hold_dr_mode) man_dr = 1'b1;

        dr_i = -1; drp_i = -1; en_i = -1; mv_i = -1; extra_ns = 0;
        for (int i = 1; i <= 2000 && mv_i < 0; i++) begin
            tick();
            if (net_newSample === 1'b1) extra_ns++;
            if (dr_i < 0 && net_dataReady === 1'b1 && prev_dr === 1'b0) dr_i = i;
            if (drp_i < 0 && net_dataReadyP === 1'b1 && prev_drp === 1'b0) drp_i = i;
            if (en_i < 0 && net_enPerceptron === 1'b1) en_i = i;
            if (m_valid === 1'b1) mv_i = i;
            prev_dr = net_dataReady; prev_drp = net_dataReadyP;
        end
        checks++;
        if (mv_i < 0) begin
            failures++;
            $display("FAIL m_valid_wait got=none exp=m_valid within 2000 cycles");
            void'(exp_data_q.pop_front());
            void'(exp_last_q.pop_front());
            return;
        end
        checks++;
        if (extra_ns != 0) begin
            failures++;
            $display("FAIL extra_newsample got=%0d exp=0", extra_ns);
        end
        checks++;
        if (dr_i < 0 || en_i - dr_i != 2) begin
            failures++;
            $display("FAIL en_latency got=%0d exp=2", en_i - dr_i);
        end
        checks++;
        if (drp_i < 0 || mv_i - drp_i != 1) begin
            failures++;
            $display("FAIL mvalid_latency got=%0d exp=1", mv_i - drp_i);
        end
        checks++;
        if (net_enPerceptron !== 1'b0) begin
            failures++;
            $display("FAIL en_drop got=%b exp=0", net_enPerceptron);
        end

        ed = exp_data_q.pop_front();
        el = exp_last_q.pop_front();
        checks++;
        if (m_data !== ed) begin
            failures++;
            $display("FAIL m_data got=%h exp=%h", m_data, ed);
        end
        checks++;
        if (m_last !== el) begin
            failures++;
            $display("FAIL m_last got=%b exp=%b (step %0d)", m_last, el, step_tb);
        end

        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (m_valid !== 1'b1 || m_data !== ed || m_last !== el ||
                    s_ready !== 1'b0 || net_newSample !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL backpressure_stable got m_valid=%b m_data=%h s_ready=%b exp 1/%h/0",
                         m_valid, m_data, s_ready, ed);
            end
        end

        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL m_valid_clear got=%b exp=0", m_valid);
        end
        if (el) begin
            step_tb = 0;
            expect_reset_pulse("seq_reset");
        end else begin
            step_tb++;
            checks++;
            if (s_ready !== 1'b1) begin
                failures++;
                $display("FAIL s_ready_return got=%b exp=1", s_ready);
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (net_reset !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got net_reset=%b s_ready=%b m_valid=%b error=%b exp 1/0/0/0",
                     net_reset, s_ready, m_valid, error);
        end
        reset = 1'b1;
        expect_reset_pulse("init_reset");
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (net_newSample !== 1'b0 || net_enPerceptron !== 1'b0 || s_ready !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_quiet got=activity exp=none");
        end
    endtask

    task automatic test_single();
        logic [VW-1:0] d;
        d = {18'h00800, 18'h3F800};
        lstm_delay = 20; perc_delay = 10;
        run_sample(d, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        lstm_delay = 3; perc_delay = 2;
        while (step_tb != 0) run_sample(rand_vec(), 0, 1'b0);
        for (int i = 0; i < SEQ_LEN; i++) run_sample(rand_vec(), 0, 1'b0);
    endtask

    task automatic test_backpressure();
        lstm_delay = 5; perc_delay = 3;
        run_sample(rand_vec(), 50, 1'b0);
        run_sample(rand_vec(), 0, 1'b0);
    endtask

    task automatic test_hold_dr();
        man_dr = 1'b1;
        manual_dr = 1'b1;
        tick();
        run_sample(rand_vec(), 0, 1'b1);
        manual_dr = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        bit saw_mv;
        lstm_delay = 0;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
        s_valid = 1'b1; s_data = rand_vec();
        tick();
        s_valid = 1'b0;
        n = 0; saw_mv = 1'b0;
        while (net_reset !== 1'b1 && n < 1200) begin
            tick(); n++;
            if (m_valid === 1'b1) saw_mv = 1'b1;
        end
        checks++;
        if (net_reset !== 1'b1 || n < 1023 || n > 1026) begin
            failures++;
            $display("FAIL timeout_cycles got=%0d exp=1023..1026", n);
        end
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL timeout_error got=%b exp=1", error);
        end
        checks++;
        if (saw_mv) begin
            failures++;
            $display("FAIL timeout_mvalid got=1 exp=0");
        end
        expect_reset_pulse("timeout_reset");
        step_tb = 0;
        lstm_delay = 4; perc_delay = 2;
        run_sample(rand_vec(), 0, 1'b0);
        checks++;
        if (error !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky got=%b exp=1", error);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit bad;
        lstm_delay = 3; perc_delay = 40;
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin tick(); n++; end
        s_valid = 1'b1; s_data = rand_vec();
        tick();
        s_valid = 1'b0;
        n = 0;
        while (net_enPerceptron !== 1'b1 && n < 100) begin tick(); n++; end
        checks++;
        if (net_enPerceptron !== 1'b1) begin
            failures++;
            $display("FAIL perc_reach got=%b exp=1", net_enPerceptron);
        end
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++;
        if (net_enPerceptron !== 1'b0 || net_reset !== 1'b1 || m_valid !== 1'b0 ||
            error !== 1'b0 || net_newSample !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got en=%b rst=%b mv=%b err=%b ns=%b rdy=%b exp 0/1/0/0/0/0",
                     net_enPerceptron, net_reset, m_valid, error, net_newSample, s_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (net_enPerceptron !== 1'b0 || net_reset !== 1'b1 || net_newSample !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_hold got=glitch exp=quiet");
        end
        reset = 1'b1;
        expect_reset_pulse("mid_reset");
        step_tb = 0;
        perc_delay = 3;
        run_sample(rand_vec(), 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_hold_dr();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/network_sequencer.md
Name: network_sequencer

Overview:
- Hardware sequencer that drives the LSTM + perceptron top-level network the same way the simulation bench does, so the network can run on-chip without a host in the loop.
- Accepts input vectors on a valid/ready stream and applies each one to the network with a one-cycle newSample pulse.
- Waits for the LSTM step to finish, runs the perceptron, and returns the scalar network output on a valid/ready stream.
- Resets the network after every SEQ_LEN samples, which marks a sequence boundary.

Parameters:
- INPUT_SZ, 2, input vector elements
- QN, 6, integer bits
- QM, 11, fractional bits (BITWIDTH = QN+QM+1 = 18)
- SEQ_LEN, 8, time steps per sequence before the network is reset
- RST_CYCLES, 4, cycles net_reset is held high (minimum 1)
- TIMEOUT, 1023, maximum cycles to wait for a completion edge (timeout counter width = log2(TIMEOUT)+1)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  sequencer can accept a sample
- s_data  in  BITWIDTH*INPUT_SZ  packed input vector, element 0 in LSBs
- net_input  out  BITWIDTH*INPUT_SZ  registered vector to the network
- net_newSample  out  1  start LSTM step
- net_reset  out  1  active-high network reset
- net_dataReady  in  1  LSTM step done (level)
- net_enPerceptron  out  1  perceptron enable
- net_dataReadyP  in  1  perceptron done (level)
- net_output  in  BITWIDTH  signed network output
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_data  out  BITWIDTH  captured network output
- m_last  out  1  result belongs to the final step of the sequence
- error  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async) sets:
  - state=NET_RST, step=0, rst_cnt=0, to_cnt=0
  - all outputs 0 except net_reset=1
  - dr_q=0, drp_q=0
- Edge detection: dr_q and drp_q register net_dataReady and net_dataReadyP every cycle in every state. A completion is a rising edge only (level=1 and q=0), so a level left high from the previous step is ignored.
- NET_RST:
  - net_reset=1 for exactly RST_CYCLES cycles, then go to IDLE.
  - step is cleared on entry.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready: latch s_data into net_input and go to ISSUE.
- ISSUE:
  - net_newSample=1 for exactly one cycle, on the cycle after the handshake.
  - Clear to_cnt, go to WAIT_L.
- WAIT_L:
  - On a net_dataReady rising edge, go to GAP.
  - to_cnt increments each cycle; when to_cnt==TIMEOUT, set error=1 and go to NET_RST. The sample is dropped and no m_valid is produced.
- GAP: one idle cycle, then go to PERC.
- PERC:
  - net_enPerceptron=1.
  - On a net_dataReadyP rising edge, capture net_output into m_data and go to OUT. net_enPerceptron goes low from the next cycle.
  - The same timeout rule as WAIT_L applies.
- OUT:
  - m_valid=1, with m_last = (step==SEQ_LEN-1).
  - m_data and m_last stay stable until m_ready is seen.
  - On m_valid&m_ready: if step==SEQ_LEN-1, go to NET_RST; else increment step and go to IDLE.
- s_ready is 0 in every state except IDLE, so only one sample is in flight.
- error is sticky and is cleared only by reset.
- Reset asserted mid-operation aborts everything immediately. net_reset=1 asynchronously, with no spurious newSample or enPerceptron pulses.
- Latencies:
  - s handshake to net_newSample: 1 cycle.
  - dataReady edge to net_enPerceptron high: 2 cycles (edge cycle + GAP).
  - dataReadyP edge to m_valid: 1 cycle.
- m_data is bit-exact with net_output (no sign or width change).

Test Plan:
- Deassert reset, s_valid held low -> net_reset=1 for exactly 4 cycles, then s_ready=1; net_newSample and net_enPerceptron stay 0.
- Send s_data={18'h00800,18'h3F800} with a network model that raises dataReady after 20 cycles and dataReadyP after 10 -> net_input matches s_data, a single net_newSample pulse, net_enPerceptron high 2 cycles after the dataReady edge, m_data equals the model output 18'h3FC00, m_last=0.
- Run 8 samples back-to-back with m_ready=1 -> m_last=1 on the 8th result only, then a 4-cycle net_reset before s_ready returns; step restarts at 0.
- Hold m_ready=0 for 50 cycles in OUT -> m_valid and m_data stable, s_ready=0, no new newSample; release -> handshake, continue.
- Model never raises dataReady -> after 1023 wait cycles error=1, net_reset pulses, no m_valid; the next sample processes normally and error stays 1.
- Hold net_dataReady high continuously from the previous step into a new one -> sequencer waits for a fresh rising edge and does not skip WAIT_L.
- Assert reset during PERC -> net_enPerceptron=0 and net_reset=1 combinationally-async, m_valid=0, error=0.
